// File: rtl/layered_mux_pkg.sv
// Shared types and constants for the layered object mux.
// Layer 0 (KONG) has the highest priority.
package layered_mux_pkg;

  typedef logic [7:0] pixel_t;

  localparam pixel_t DEFAULT_TRANSPARENT_COLOR = 8'hFF;

  localparam int KONG     = 0;
  localparam int TARGET   = 1;
  localparam int ROPE     = 2;
  localparam int PLATFORM = 3;

  // Width of a layer index; never below one bit, even for tiny layer counts.
  function automatic int layerIdxW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layered_objects_mux_prio_encoder.sv
// Combinational lowest-set-bit priority encoder.
// idx is 0 whenever no request bit is set.
module prio_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one assigned.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/layered_objects_mux.sv
// Two-stage priority mux of NUM_LAYERS object layers over a background,
// with a frame-synchronous enable mask and per-frame collision reporting.
// Optional colour keying: define LAYERED_MUX_TRANSPARENCY_KEY_EN.
module layered_objects_mux
  import layered_mux_pkg::*;
#(
  parameter int               NUM_LAYERS        = 8,
  parameter int               PIX_W             = 8,
  parameter logic [PIX_W-1:0] TRANSPARENT_COLOR = PIX_W'(DEFAULT_TRANSPARENT_COLOR)
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [NUM_LAYERS-1:0]         drawingRequest,
  input  logic [NUM_LAYERS*PIX_W-1:0]   layerRGB,
  input  logic [PIX_W-1:0]              backGroundRGB,
  input  logic                          layerEnWr,
  input  logic [NUM_LAYERS-1:0]         layerEnIn,
  output logic [PIX_W-1:0]              RGBOut,
  output logic                          winnerValid,
  output logic [$clog2(NUM_LAYERS)-1:0] winnerIdx,
  output logic                          collisionFrame,
  output logic [NUM_LAYERS-1:0]         collisionMask
);

  localparam int IDX_W = layerIdxW(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]       shadowMask;
  logic [NUM_LAYERS-1:0]       activeMask;
  logic [NUM_LAYERS-1:0]       act;
  logic [NUM_LAYERS-1:0]       act1;
  logic [NUM_LAYERS*PIX_W-1:0] rgb1;
  logic [PIX_W-1:0]            bg1;
  logic                        collide;
  logic                        stickyFlag;
  logic [NUM_LAYERS-1:0]       stickyMask;
  logic                        winValid;
  logic [IDX_W-1:0]            winIdx;
  logic [PIX_W-1:0]            winRGB;

  // The active mask only moves at a frame start; a simultaneous write goes straight through.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadowMask <= '1;
      activeMask <= '1;
    end else begin
      if (layerEnWr)
        shadowMask <= layerEnIn;
      if (startOfFrame)
        activeMask <= layerEnWr ? layerEnIn : shadowMask;
    end
  end

`ifdef LAYERED_MUX_TRANSPARENCY_KEY_EN
  logic [NUM_LAYERS-1:0] opaque;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = (layerRGB[i*PIX_W +: PIX_W] != TRANSPARENT_COLOR);
    act = drawingRequest & activeMask & opaque;
  end
`else
  logic unusedKey;
  assign unusedKey = ^TRANSPARENT_COLOR;

  always_comb begin
    act = drawingRequest & activeMask;
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act1 <= '0;
      rgb1 <= '0;
      bg1  <= '0;
    end else begin
      act1 <= act;
      rgb1 <= layerRGB;
      bg1  <= backGroundRGB;
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign collide = |(act1 & (act1 - NUM_LAYERS'(1)));

  prio_encoder #(.N(NUM_LAYERS)) u_prio (
    .req   (act1),
    .valid (winValid),
    .idx   (winIdx)
  );

  assign winRGB = rgb1[winIdx*PIX_W +: PIX_W];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut      <= '0;
      winnerValid <= 1'b0;
      winnerIdx   <= '0;
    end else begin
      RGBOut      <= winValid ? winRGB : bg1;
      winnerValid <= winValid;
      winnerIdx   <= winIdx;
    end
  end

  // The frame-start pixel still belongs to the closing frame's report, not the new one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stickyFlag     <= 1'b0;
      stickyMask     <= '0;
      collisionFrame <= 1'b0;
      collisionMask  <= '0;
    end else if (startOfFrame) begin
      collisionFrame <= stickyFlag | collide;
      collisionMask  <= stickyMask | (collide ? act1 : '0);
      stickyFlag     <= 1'b0;
      stickyMask     <= '0;
    end else if (collide) begin
      stickyFlag <= 1'b1;
      stickyMask <= stickyMask | act1;
    end
  end

endmodule

// File: tb/tb_layered_objects_mux.sv
// Directed, table-driven bench for layered_objects_mux with NUM_LAYERS=4.
module tb_layered_objects_mux;

  localparam int NL = 4;

  logic          clk;
  logic          resetN;
  logic          startOfFrame;
  logic [NL-1:0] drawingRequest;
  logic [31:0]   layerRGB;
  logic [7:0]    backGroundRGB;
  logic          layerEnWr;
  logic [NL-1:0] layerEnIn;
  logic [7:0]    RGBOut;
  logic          winnerValid;
  logic [1:0]    winnerIdx;
  logic          collisionFrame;
  logic [NL-1:0] collisionMask;

  int assertCount = 0;
  int failCount   = 0;

  layered_objects_mux #(.NUM_LAYERS(NL), .PIX_W(8)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .drawingRequest (drawingRequest),
    .layerRGB       (layerRGB),
    .backGroundRGB  (backGroundRGB),
    .layerEnWr      (layerEnWr),
    .layerEnIn      (layerEnIn),
    .RGBOut         (RGBOut),
    .winnerValid    (winnerValid),
    .winnerIdx      (winnerIdx),
    .collisionFrame (collisionFrame),
    .collisionMask  (collisionMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] req;
    logic [31:0]   rgb;
    logic [7:0]    bg;
    logic [7:0]    expRGB;
    logic          expValid;
    logic [1:0]    expIdx;
  } vec_t;

  vec_t vecs [8];

  localparam logic [31:0] RGB_DEF = 32'h33221100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NL-1:0] req, input logic [31:0] rgb,
                               input logic [7:0] bg);
    drawingRequest = req;
    layerRGB       = rgb;
    backGroundRGB  = bg;
  endtask

  task automatic pulseFrame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expRGB,
                             input logic expValid, input logic [1:0] expIdx);
    assertCount += 3;
    if (RGBOut !== expRGB) begin
      failCount++;
      $display("[TB] FAIL %s RGBOut got %h expected %h", name, RGBOut, expRGB);
    end
    if (winnerValid !== expValid) begin
      failCount++;
      $display("[TB] FAIL %s winnerValid got %b expected %b", name, winnerValid, expValid);
    end
    if (winnerIdx !== expIdx) begin
      failCount++;
      $display("[TB] FAIL %s winnerIdx got %0d expected %0d", name, winnerIdx, expIdx);
    end
  endtask

  task automatic checkCollision(input string name, input logic expFlag,
                                input logic [NL-1:0] expMask);
    assertCount += 2;
    if (collisionFrame !== expFlag) begin
      failCount++;
      $display("[TB] FAIL %s collisionFrame got %b expected %b", name, collisionFrame, expFlag);
    end
    if (collisionMask !== expMask) begin
      failCount++;
      $display("[TB] FAIL %s collisionMask got %b expected %b", name, collisionMask, expMask);
    end
  endtask

  initial begin
    vecs[0] = '{4'b1010, RGB_DEF,      8'h55, 8'h11, 1'b1, 2'd1};
    vecs[1] = '{4'b0000, RGB_DEF,      8'hA5, 8'hA5, 1'b0, 2'd0};
    vecs[2] = '{4'b0000, RGB_DEF,      8'h5A, 8'h5A, 1'b0, 2'd0};
    vecs[3] = '{4'b0000, RGB_DEF,      8'hA5, 8'hA5, 1'b0, 2'd0};
    vecs[4] = '{4'b1000, RGB_DEF,      8'h55, 8'h33, 1'b1, 2'd3};
    vecs[5] = '{4'b0100, RGB_DEF,      8'h55, 8'h22, 1'b1, 2'd2};
    vecs[6] = '{4'b1111, 32'h3322119C, 8'h55, 8'h9C, 1'b1, 2'd0};
    vecs[7] = '{4'b0001, 32'h33221177, 8'h55, 8'h77, 1'b1, 2'd0};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    layerEnWr    = 1'b0;
    layerEnIn    = '0;
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    step();
    checkOutput("reset", 8'h00, 1'b0, 2'd0);
    checkCollision("reset", 1'b0, 4'b0000);
    resetN = 1'b1;
    step();

    // Back-to-back pixels: result of vector i-1 is visible after vector i is clocked in.
    pulseFrame();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) applyStimulus(vecs[i].req, vecs[i].rgb, vecs[i].bg);
      else       applyStimulus('0, RGB_DEF, 8'h55);
      step();
      if (i >= 1)
        checkOutput($sformatf("vec%0d", i - 1), vecs[i-1].expRGB,
                    vecs[i-1].expValid, vecs[i-1].expIdx);
    end
    pulseFrame();
    checkCollision("table_frame", 1'b1, 4'b1111);

    // Mid-frame mask write must not take effect until the next frame start.
    applyStimulus(4'b0010, RGB_DEF, 8'h55);
    layerEnWr = 1'b1;
    layerEnIn = 4'b1101;
    step();
    layerEnWr = 1'b0;
    step();
    checkOutput("midframe_a", 8'h11, 1'b1, 2'd1);
    step();
    checkOutput("midframe_b", 8'h11, 1'b1, 2'd1);
    step();
    checkOutput("midframe_c", 8'h11, 1'b1, 2'd1);
    pulseFrame();
    checkCollision("single_layer_frame", 1'b0, 4'b0000);
    step();
    step();
    checkOutput("masked_after_sof", 8'h55, 1'b0, 2'd0);

    // Re-enable all layers, then frame A with one colliding pixel.
    applyStimulus('0, RGB_DEF, 8'h55);
    layerEnWr = 1'b1;
    layerEnIn = 4'b1111;
    step();
    layerEnWr = 1'b0;
    pulseFrame();
    applyStimulus(4'b0110, RGB_DEF, 8'h55);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    checkOutput("frameA_pixel", 8'h11, 1'b1, 2'd1);
    step();
    pulseFrame();
    checkCollision("frameA_report", 1'b1, 4'b0110);
    applyStimulus(4'b0100, RGB_DEF, 8'h55);
    step();
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    step();
    checkCollision("frameA_hold", 1'b1, 4'b0110);
    pulseFrame();
    checkCollision("frameB_report", 1'b0, 4'b0000);

    // Write-through: mask write coinciding with frame start.
    layerEnWr = 1'b1;
    layerEnIn = 4'b0001;
    pulseFrame();
    layerEnWr = 1'b0;
    applyStimulus(4'b0011, 32'h33221177, 8'h55);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    checkOutput("writethrough", 8'h77, 1'b1, 2'd0);
    step();
    pulseFrame();
    checkCollision("writethrough_nocoll", 1'b0, 4'b0000);
    applyStimulus(4'b0010, RGB_DEF, 8'h66);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    checkOutput("shadow_kept", 8'h66, 1'b0, 2'd0);

    // Transparency key behaviour depends on the build.
    layerEnWr = 1'b1;
    layerEnIn = 4'b1111;
    pulseFrame();
    layerEnWr = 1'b0;
    applyStimulus(4'b0011, 32'h33221CFF, 8'h55);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
`ifdef LAYERED_MUX_TRANSPARENCY_KEY_EN
    checkOutput("key_pixel", 8'h1C, 1'b1, 2'd1);
`else
    checkOutput("key_pixel", 8'hFF, 1'b1, 2'd0);
`endif
    step();
    pulseFrame();
`ifdef LAYERED_MUX_TRANSPARENCY_KEY_EN
    checkCollision("key_coll", 1'b0, 4'b0000);
`else
    checkCollision("key_coll", 1'b1, 4'b0011);
`endif

    // Reset mid-frame with a pending collision: everything is lost.
    applyStimulus(4'b0110, RGB_DEF, 8'h55);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    step();
    resetN = 1'b0;
    #2;
    checkOutput("async_reset", 8'h00, 1'b0, 2'd0);
    checkCollision("async_reset", 1'b0, 4'b0000);
    step();
    resetN = 1'b1;
    step();
    pulseFrame();
    checkCollision("first_sof_after_reset", 1'b0, 4'b0000);
    applyStimulus(4'b1000, RGB_DEF, 8'h55);
    step();
    applyStimulus('0, RGB_DEF, 8'h55);
    step();
    checkOutput("mask_after_reset", 8'h33, 1'b1, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
